// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code decoder: default width, step encodings and
// a width-agnostic Gray-to-binary helper.
package gray_pkg;

   localparam int unsigned DEFAULT_WIDTH = 4;
   localparam int unsigned GRAY_MAX_W    = 64;

   typedef enum logic [1:0] {
      STEP_HOLD    = 2'b00,
      STEP_UP      = 2'b01,
      STEP_DOWN    = 2'b10,
      STEP_ILLEGAL = 2'b11
   } step_dir_e;

   // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
   // Zero-extended inputs decode correctly because the padding bits contribute nothing.
   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
      logic [GRAY_MAX_W-1:0] b;
      b = g;
      for (int i = 1; i < GRAY_MAX_W; i++) begin
         b ^= g >> i;
      end
      return b;
   endfunction

endpackage

// File: rtl/gray2bin_comb.sv
// Purely combinational Gray-to-binary converter, MSB of gray_i is the most significant bit.
module gray2bin_comb
   import gray_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] gray_i,
   output logic [WIDTH-1:0] bin_o
);

   assign bin_o = WIDTH'(gray2bin(GRAY_MAX_W'(gray_i)));

endmodule

// File: rtl/gray_decoder.sv
// Registered Gray-to-binary decoder with valid/ready handshake and a single-step checker
// reporting step direction, a sticky error flag and a saturating error counter.
module gray_decoder
   import gray_pkg::*;
#(
   parameter int unsigned WIDTH     = DEFAULT_WIDTH,
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     gray_in,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [WIDTH-1:0]     bin_out,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [1:0]           step_dir,
   output logic                 step_err,
   output logic [ERR_CNT_W-1:0] err_count,
   input  logic                 clr_err
);

   logic [WIDTH-1:0]     bin_dec;
   logic [WIDTH-1:0]     delta;
   logic                 accept;
   step_dir_e            dir_calc;

   logic [WIDTH-1:0]     bin_q, bin_d;
   logic                 out_valid_q, out_valid_d;
   step_dir_e            dir_q, dir_d;
   logic                 err_q, err_d;
   logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]     prev_bin_q, prev_bin_d;
   logic                 prev_valid_q, prev_valid_d;

   gray2bin_comb #(
      .WIDTH (WIDTH)
   ) u_gray2bin (
      .gray_i (gray_in),
      .bin_o  (bin_dec)
   );

   always_comb begin
      in_ready = !out_valid_q || out_ready;
      accept   = in_valid && in_ready;
      delta    = bin_dec - prev_bin_q;

      // Modular difference makes max->0 an up step and 0->max a down step.
      dir_calc = STEP_ILLEGAL;
      if (!prev_valid_q || (delta == '0)) begin
         dir_calc = STEP_HOLD;
      end else if (delta == WIDTH'(1)) begin
         dir_calc = STEP_UP;
      end else if (delta == '1) begin
         dir_calc = STEP_DOWN;
      end

      bin_d        = bin_q;
      out_valid_d  = out_valid_q;
      dir_d        = dir_q;
      err_d        = err_q;
      cnt_d        = cnt_q;
      prev_bin_d   = prev_bin_q;
      prev_valid_d = prev_valid_q;

      if (accept) begin
         bin_d        = bin_dec;
         out_valid_d  = 1'b1;
         dir_d        = dir_calc;
         prev_bin_d   = bin_dec;
         prev_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      // A clear in the same cycle as an illegal jump drops that error.
      if (clr_err) begin
         err_d = 1'b0;
         cnt_d = '0;
      end else if (accept && (dir_calc == STEP_ILLEGAL)) begin
         err_d = 1'b1;
         if (cnt_q != '1) begin
            cnt_d = cnt_q + ERR_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_q        <= '0;
         out_valid_q  <= 1'b0;
         dir_q        <= STEP_HOLD;
         err_q        <= 1'b0;
         cnt_q        <= '0;
         prev_bin_q   <= '0;
         prev_valid_q <= 1'b0;
      end else begin
         bin_q        <= bin_d;
         out_valid_q  <= out_valid_d;
         dir_q        <= dir_d;
         err_q        <= err_d;
         cnt_q        <= cnt_d;
         prev_bin_q   <= prev_bin_d;
         prev_valid_q <= prev_valid_d;
      end
   end

   assign bin_out   = bin_q;
   assign out_valid = out_valid_q;
   assign step_dir  = dir_q;
   assign step_err  = err_q;
   assign err_count = cnt_q;

endmodule

// File: tb/tb_gray_decoder.sv
// Self-checking bench for gray_decoder: directed scenarios plus randomized handshake traffic
// compared against an arithmetic reference model.
module tb_gray_decoder;

   localparam int W  = 4;
   localparam int CW = 8;
   localparam int MOD = 1 << W;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [W-1:0]  gray_in = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  bin_out;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [1:0]    step_dir;
   logic          step_err;
   logic [CW-1:0] err_count;
   logic          clr_err = 1'b0;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int m_ov, m_bin, m_dir, m_pv, m_prev, m_err, m_cnt;
   bit obs_ready_pre, exp_ready_pre;

   gray_decoder #(
      .WIDTH     (W),
      .ERR_CNT_W (CW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .gray_in   (gray_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bin_out   (bin_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .step_dir  (step_dir),
      .step_err  (step_err),
      .err_count (err_count),
      .clr_err   (clr_err)
   );

   always #5 clk = ~clk;

   // Decode by searching for the integer whose Gray code matches.
   function automatic int ref_decode(input int g);
      for (int n = 0; n < MOD; n++) begin
         if ((n ^ (n >> 1)) == g) return n;
      end
      return -1;
   endfunction

   function automatic int to_gray(input int n);
      return (n ^ (n >> 1)) % MOD;
   endfunction

   task automatic model_reset();
      m_ov = 0; m_bin = 0; m_dir = 0; m_pv = 0; m_prev = 0; m_err = 0; m_cnt = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; in_valid = 1'b0; clr_err = 1'b0; out_ready = 1'b1; gray_in = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Drive one cycle of inputs, advance the model, return at posedge+1.
   task automatic drive_cycle(input bit iv, input int g, input bit ordy, input bit clr);
      int nb, d, dir;
      bit acc;
      in_valid = iv; gray_in = g[W-1:0]; out_ready = ordy; clr_err = clr;
      #1;
      obs_ready_pre = in_ready;
      exp_ready_pre = (m_ov == 0) || ordy;
      acc = iv && exp_ready_pre;
      if (acc) begin
         nb = ref_decode(g % MOD);
         d  = (nb - m_prev + MOD) % MOD;
         if (m_pv == 0 || d == 0) dir = 0;
         else if (d == 1) dir = 1;
         else if (d == MOD - 1) dir = 2;
         else dir = 3;
         m_bin = nb; m_dir = dir; m_prev = nb; m_pv = 1; m_ov = 1;
      end else if (ordy) begin
         m_ov = 0;
         dir = 0;
      end else begin
         dir = 0;
      end
      if (clr) begin
         m_err = 0; m_cnt = 0;
      end else if (acc && dir == 3) begin
         m_err = 1;
         if (m_cnt < (1 << CW) - 1) m_cnt++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (out_valid !== 1'b0 || bin_out !== 4'h0 || step_dir !== 2'b00) begin
         errors++;
         $display("FAIL reset_outputs got ov=%0b bin=%0h dir=%0b exp 0/0/0", out_valid, bin_out,
                  step_dir);
      end
      checks++;
      if (step_err !== 1'b0 || err_count !== 8'h00 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_status got err=%0b cnt=%0h rdy=%0b exp 0/0/1", step_err, err_count,
                  in_ready);
      end
   endtask

   task automatic test_first_word();
      do_reset();
      drive_cycle(1, 4'b1111, 1, 0);
      checks++;
      if (bin_out !== 4'b1010 || out_valid !== 1'b1 || step_dir !== 2'b00) begin
         errors++;
         $display("FAIL first_word got bin=%0b ov=%0b dir=%0b exp 1010/1/00", bin_out, out_valid,
                  step_dir);
      end
   endtask

   task automatic test_stream_up();
      int g[4] = '{0, 1, 3, 2};
      int d[4] = '{0, 1, 1, 1};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive_cycle(1, g[i], 1, 0);
         checks++;
         if (bin_out !== W'(i) || step_dir !== d[i][1:0] || step_err !== 1'b0) begin
            errors++;
            $display("FAIL stream_up[%0d] got bin=%0d dir=%0b err=%0b exp %0d/%0b/0", i, bin_out,
                     step_dir, step_err, i, d[i][1:0]);
         end
      end
   endtask

   task automatic test_wrap();
      do_reset();
      drive_cycle(1, 4'b0000, 1, 0);
      drive_cycle(1, 4'b1000, 1, 0);
      checks++;
      if (bin_out !== 4'd15 || step_dir !== 2'b10) begin
         errors++;
         $display("FAIL wrap_down got bin=%0d dir=%0b exp 15/10", bin_out, step_dir);
      end
      drive_cycle(1, 4'b0000, 1, 0);
      checks++;
      if (bin_out !== 4'd0 || step_dir !== 2'b01 || step_err !== 1'b0) begin
         errors++;
         $display("FAIL wrap_up got bin=%0d dir=%0b err=%0b exp 0/01/0", bin_out, step_dir,
                  step_err);
      end
   endtask

   task automatic test_illegal_clear();
      do_reset();
      drive_cycle(1, 4'b0000, 1, 0);
      drive_cycle(1, 4'b0011, 1, 0);
      checks++;
      if (bin_out !== 4'd2 || step_dir !== 2'b11 || step_err !== 1'b1 || err_count !== 8'd1) begin
         errors++;
         $display("FAIL illegal got bin=%0d dir=%0b err=%0b cnt=%0d exp 2/11/1/1", bin_out,
                  step_dir, step_err, err_count);
      end
      drive_cycle(0, 0, 1, 1);
      checks++;
      if (step_err !== 1'b0 || err_count !== 8'd0) begin
         errors++;
         $display("FAIL clear got err=%0b cnt=%0d exp 0/0", step_err, err_count);
      end
      // 2 -> 0 is illegal but coincides with a clear, so it is dropped.
      drive_cycle(1, 4'b0000, 1, 1);
      checks++;
      if (step_dir !== 2'b11 || step_err !== 1'b0 || err_count !== 8'd0) begin
         errors++;
         $display("FAIL clear_wins got dir=%0b err=%0b cnt=%0d exp 11/0/0", step_dir, step_err,
                  err_count);
      end
      drive_cycle(1, 4'b0001, 1, 0);
      checks++;
      if (step_dir !== 2'b01 || bin_out !== 4'd1 || step_err !== 1'b0) begin
         errors++;
         $display("FAIL clear_keeps_history got dir=%0b bin=%0d err=%0b exp 01/1/0", step_dir,
                  bin_out, step_err);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      drive_cycle(1, to_gray(6), 0, 0);
      checks++;
      if (out_valid !== 1'b1 || bin_out !== 4'd6) begin
         errors++;
         $display("FAIL bp_load got ov=%0b bin=%0d exp 1/6", out_valid, bin_out);
      end
      for (int i = 0; i < 5; i++) begin
         drive_cycle(1, $urandom_range(0, MOD - 1), 0, 0);
         checks++;
         if (obs_ready_pre !== 1'b0 || bin_out !== 4'd6 || out_valid !== 1'b1
             || step_dir !== 2'b00) begin
            errors++;
            $display("FAIL bp_hold[%0d] got rdy=%0b bin=%0d ov=%0b dir=%0b exp 0/6/1/00", i,
                     obs_ready_pre, bin_out, out_valid, step_dir);
         end
      end
      drive_cycle(1, to_gray(5), 1, 0);
      checks++;
      if (obs_ready_pre !== 1'b1 || out_valid !== 1'b1 || bin_out !== 4'd5
          || step_dir !== 2'b10) begin
         errors++;
         $display("FAIL bp_release got rdy=%0b ov=%0b bin=%0d dir=%0b exp 1/1/5/10",
                  obs_ready_pre, out_valid, bin_out, step_dir);
      end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      drive_cycle(1, to_gray(3), 0, 0);
      drive_cycle(1, to_gray(4), 1, 0);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || bin_out !== 4'd0) begin
         errors++;
         $display("FAIL async_reset got ov=%0b bin=%0d exp 0/0", out_valid, bin_out);
      end
      #2 rst_n = 1'b1;
      model_reset();
      drive_cycle(1, to_gray(9), 1, 0);
      checks++;
      if (step_dir !== 2'b00 || bin_out !== 4'd9 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL after_reset got dir=%0b bin=%0d ov=%0b exp 00/9/1", step_dir, bin_out,
                  out_valid);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 300; i++) begin
         drive_cycle(1, (i % 2 == 0) ? 0 : 3, 1, 0);
         if (i == 254) begin
            checks++;
            if (err_count !== 8'd254) begin
               errors++;
               $display("FAIL sat_pre got cnt=%0d exp 254", err_count);
            end
         end
      end
      checks++;
      if (err_count !== 8'hFF || step_err !== 1'b1) begin
         errors++;
         $display("FAIL saturate got cnt=%0h err=%0b exp ff/1", err_count, step_err);
      end
   endtask

   task automatic test_random();
      int cur, g;
      do_reset();
      cur = 0;
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0: cur = (cur + 1) % MOD;
            1: cur = (cur + MOD - 1) % MOD;
            2: cur = cur;
            default: cur = $urandom_range(0, MOD - 1);
         endcase
         g = to_gray(cur);
         drive_cycle($urandom_range(0, 3) != 0, g, $urandom_range(0, 2) != 0,
                     $urandom_range(0, 19) == 0);
         checks++;
         if (obs_ready_pre !== exp_ready_pre || out_valid !== m_ov[0]) begin
            errors++;
            $display("FAIL rand_hs[%0d] got rdy=%0b ov=%0b exp %0b/%0b", i, obs_ready_pre,
                     out_valid, exp_ready_pre, m_ov[0]);
         end
         if (m_ov != 0) begin
            checks++;
            if (bin_out !== m_bin[W-1:0] || step_dir !== m_dir[1:0]) begin
               errors++;
               $display("FAIL rand_data[%0d] got bin=%0d dir=%0b exp %0d/%0b", i, bin_out,
                        step_dir, m_bin, m_dir[1:0]);
            end
         end
         checks++;
         if (step_err !== m_err[0] || err_count !== m_cnt[CW-1:0]) begin
            errors++;
            $display("FAIL rand_err[%0d] got err=%0b cnt=%0d exp %0b/%0d", i, step_err,
                     err_count, m_err[0], m_cnt);
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_word();
      test_stream_up();
      test_wrap();
      test_illegal_clear();
      test_backpressure();
      test_reset_midstream();
      test_saturation();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
